mult_share_arbiter: RTL and testbench

Round-robin arbiter that shares one unsigned Wallace-tree multiplier among NUM_REQ requesters inside the PE. Accepted operand pairs pass through a two-stage registered pipeline: operand register, then the multiplier feeding a product register. Each result is returned with the ID of the requester that issued it. Valid/ready handshakes on both sides, full backpressure, throughput of one product per cycle.

---
 rtl/mult_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one unsigned Wallace-tree multiplier among NUM_REQ requesters.
// Two registered stages (operands, product) with valid/ready handshakes on both sides.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN1_W   = 8,
    parameter int IN2_W   = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*IN1_W-1:0]   req_in1,
    input  logic [NUM_REQ*IN2_W-1:0]   req_in2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            out_id,
    output logic [IN1_W+IN2_W-1:0]     out_product,
    output logic                       busy
);

    localparam int P_W = IN1_W + IN2_W;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    nxt_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [IN1_W-1:0]   gnt_in1;
    logic [IN2_W-1:0]   gnt_in2;

    logic               s1_valid;
    logic [IN1_W-1:0]   s1_in1;
    logic [IN2_W-1:0]   s1_in2;
    logic [ID_W-1:0]    s1_id;
    logic               s2_valid;
    logic [P_W-1:0]     s2_prod;
    logic [ID_W-1:0]    s2_id;

    logic               s1_adv;
    logic               s2_adv;
    logic               accept;
    logic [P_W-1:0]     mult_p;

    // Search starts at ptr and wraps, so the first valid requester found wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_in1 = '0;
        gnt_in2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any    = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = ID_W'(idx);
                gnt_in1    = req_in1[idx*IN1_W +: IN1_W];
                gnt_in2    = req_in2[idx*IN2_W +: IN2_W];
            end
        end
    end

    assign nxt_ptr   = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign accept    = gnt_any && s1_adv;
    assign req_ready = grant & {NUM_REQ{s1_adv && rst_n}};

    // Wallace reduction: compress partial-product rows 3:2 per level until two remain.
    always_comb begin
        logic [P_W-1:0] cur [IN2_W];
        logic [P_W-1:0] nxt [IN2_W];
        int n;
        int m;
        for (int i = 0; i < IN2_W; i++) begin
            cur[i] = s1_in2[i] ? (P_W'(s1_in1) << i) : '0;
            nxt[i] = '0;
        end
        n = IN2_W;
        m = 0;
        for (int lvl = 0; lvl < IN2_W; lvl++) begin
            if (n > 2) begin
                for (int i = 0; i < IN2_W; i++) nxt[i] = '0;
                m = 0;
                for (int g = 0; g < IN2_W / 3; g++) begin
                    if (3 * g + 2 < n) begin
                        nxt[m]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                        nxt[m + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2])
                                     | (cur[3*g+1] & cur[3*g+2])) << 1;
                        m = m + 2;
                    end
                end
                for (int r = 0; r < IN2_W; r++) begin
                    if (r >= 3 * (n / 3) && r < n) begin
                        nxt[m] = cur[r];
                        m = m + 1;
                    end
                end
                n = m;
                for (int i = 0; i < IN2_W; i++) cur[i] = nxt[i];
            end
        end
        mult_p = '0;
        for (int i = 0; i < IN2_W && i < 2; i++) begin
            if (i < n) mult_p = mult_p + cur[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_in1   <= '0;
            s1_in2   <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_id    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_in1 <= gnt_in1;
                    s1_in2 <= gnt_in2;
                    s1_id  <= gnt_id;
                    ptr    <= nxt_ptr;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_prod <= mult_p;
                    s2_id   <= s1_id;
                end
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_product = s2_prod;
    assign out_id      = s2_id;
    assign busy        = s1_valid || s2_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: queue-based reference model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [15:0] out_product;
    logic        busy;

    mult_share_arbiter #(.NUM_REQ(4), .IN1_W(8), .IN2_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_product (out_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         rem  [4];
    int         nser [4];
    logic [7:0] op1  [4];
    logic [7:0] op2  [4];
    logic [3:0] last_acc = '0;

    // Model: in-flight entries in acceptance order; age counts edges since acceptance.
    // The oldest entry sits in the output stage once its age reaches 2.
    typedef struct {
        int id;
        int prod;
        int age;
    } ent_t;
    ent_t q[$];
    int   m_ptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : model
        int g;
        int k;
        logic ov;
        logic acc;
        logic [3:0] er;
        if (!rst_n) begin
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_id", 32'(out_id), 32'd0);
            chk("rst_product", 32'(out_product), 32'd0);
            q.delete();
            m_ptr = 0;
            last_acc = '0;
        end else begin
            g = -1;
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (g < 0 && req_valid[k]) g = k;
            end
            ov  = (q.size() > 0) && (q[0].age >= 2);
            acc = (g >= 0) && (q.size() < 2 || out_ready);
            er  = acc ? 4'(1 << g) : 4'd0;
            chk("m_ready", 32'(req_ready), 32'(er));
            chk("m_valid", 32'(out_valid), 32'(ov));
            chk("m_busy", 32'(busy), 32'(q.size() > 0));
            if (ov) begin
                chk("m_id", 32'(out_id), 32'(q[0].id));
                chk("m_product", 32'(out_product), 32'(q[0].prod));
            end
            if (ov && out_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (acc) begin
                q.push_back('{g, int'(op1[g]) * int'(op2[g]), 1});
                m_ptr = (g + 1) % 4;
            end
            last_acc = er;
        end
    end

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_valid[k]       = rem[k] > 0;
            req_in1[k*8 +: 8]  = op1[k];
            req_in2[k*8 +: 8]  = op2[k];
        end
    endtask

    // Advance one edge; accepted requesters move on to their next operand pair.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (last_acc[k]) begin
                rem[k]  = rem[k] - 1;
                nser[k] = nser[k] + 1;
                op1[k]  = 8'(k * 37 + nser[k] * 11 + 3);
                op2[k]  = 8'(k * 53 + nser[k] * 7 + 1);
            end
        end
        drive();
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 4; k++) rem[k] = 0;
        drive();
    endtask

    task automatic reset_dut();
        step();
        rst_n = 1'b0;
        clear_reqs();
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            step();
        end
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int nacc;
        logic [15:0] bp_prod;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0; nser[k] = 0; op1[k] = '0; op2[k] = '0;
        end
        drive();
        @(negedge clk);
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;

        // Single request on requester 2
        rem[2] = 1; op1[2] = 8'd13; op2[2] = 8'd11;
        drive();
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        step();
        step();
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_id", 32'(out_id), 32'd2);
        chk("t1_product", 32'(out_product), 32'd143);
        step();
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'd0);

        // Max operands
        rem[0] = 1; op1[0] = 8'd255; op2[0] = 8'd255;
        drive();
        step();
        step();
        @(negedge clk);
        chk("max_product", 32'(out_product), 32'd65025);
        chk("max_id", 32'(out_id), 32'd0);
        step();
        drain();

        // Fairness with all requesters valid
        reset_dut();
        for (int k = 0; k < 4; k++) rem[k] = 100;
        drive();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("fair_ready", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("fair_valid", 32'(out_valid), 32'd1);
                chk("fair_id", 32'(out_id), 32'((c - 2) % 4));
            end
            step();
        end
        clear_reqs();
        drain();

        // Backpressure: out_ready low for 5 cycles
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rem[k] = 100; op1[k] = 8'(k + 2); op2[k] = 8'd10;
        end
        drive();
        nacc = 0;
        bp_prod = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'd0) nacc++;
            if (c == 2) bp_prod = out_product;
            if (c >= 2) begin
                chk("bp_product", 32'(out_product), 32'd20);
                chk("bp_id", 32'(out_id), 32'd0);
            end
            step();
        end
        chk("bp_accepts", 32'(nacc), 32'd2);
        chk("bp_stable", 32'(out_product), 32'(bp_prod));
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        clear_reqs();
        drain();

        // Pointer skip: only 1 and 3 valid with ptr at 2
        reset_dut();
        rem[1] = 1;
        drive();
        step();
        rem[1] = 2; rem[3] = 2;
        drive();
        @(negedge clk);
        chk("ps_grant0", 32'(req_ready), 32'b1000);
        step();
        @(negedge clk);
        chk("ps_grant1", 32'(req_ready), 32'b0010);
        step();
        @(negedge clk);
        chk("ps_grant2", 32'(req_ready), 32'b1000);
        step();
        clear_reqs();
        drain();

        // Async reset with both stages full
        reset_dut();
        for (int k = 0; k < 4; k++) rem[k] = 100;
        drive();
        step();
        step();
        step();
        chk("ar_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        clear_reqs();
        #1;
        chk("ar_valid_drop", 32'(out_valid), 32'd0);
        chk("ar_busy_drop", 32'(busy), 32'd0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        rem[1] = 1; op1[1] = 8'd7; op2[1] = 8'd9;
        drive();
        @(negedge clk);
        chk("ar_ready", 32'(req_ready), 32'b0010);
        step();
        step();
        @(negedge clk);
        chk("ar_valid", 32'(out_valid), 32'd1);
        chk("ar_id", 32'(out_id), 32'd1);
        chk("ar_product", 32'(out_product), 32'd63);
        step();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
